wb_gpio_debounce: RTL

- Wishbone classic slave GPIO controller with a configurable number of channels.
- Inputs: per-channel 2-flop synchroniser, per-channel debounce counter, edge-selectable sticky interrupt status; outputs: data/direction registers.
- Replaces hard-wired LED/IO/KEY pins on board tops: LED[3:0], IO[7:0] and KEY1 all attach through instances of this block on the SoC Wishbone bus.

---
 rtl/wb_gpio_debounce_if.sv | 22 ++
 rtl/wb_gpio_debounce.sv | 112 +++++++++++
 2 files changed

// File: rtl/wb_gpio_debounce_if.sv
// rtl/wb_gpio_debounce_if.sv - Wishbone classic bus bundle for the GPIO debounce controller
interface wb_gpio_debounce_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_gpio_debounce.sv
// rtl/wb_gpio_debounce.sv - Wishbone GPIO slave with synchronised, debounced inputs and sticky edge IRQs
module wb_gpio_debounce #(
  parameter int GPIO_WIDTH       = 8,
  parameter int DEBOUNCE_WIDTH   = 16,
  parameter int DEBOUNCE_DEFAULT = 24000,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET = '0,
  parameter logic [GPIO_WIDTH-1:0] DIR_RESET = '0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_gpio_debounce_if.slave     bus,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);
  localparam logic [DEBOUNCE_WIDTH-1:0] DB_RST = DEBOUNCE_WIDTH'(DEBOUNCE_DEFAULT);

  logic [GPIO_WIDTH-1:0]     data_out, dir, irq_mask, irq_edge, irq_status;
  logic [DEBOUNCE_WIDTH-1:0] debounce;
  logic [GPIO_WIDTH-1:0]     sync1, raw, stable, stable_nxt, ev, clr;
  logic [DEBOUNCE_WIDTH-1:0] cnt [GPIO_WIDTH];
  logic                      deb_load, ack, irq;
  logic [31:0]               dat, rdata, bmask, wbits, merged;
  logic                      req, wr;
  logic [2:0]                word;
  logic                      unused_bits;

  assign req   = bus.wb_cyc_i & bus.wb_stb_i & ~ack;
  assign wr    = req & bus.wb_we_i;
  assign word  = bus.wb_adr_i[4:2];
  assign bmask = {{8{bus.wb_sel_i[3]}}, {8{bus.wb_sel_i[2]}},
                  {8{bus.wb_sel_i[1]}}, {8{bus.wb_sel_i[0]}}};
  assign wbits  = bus.wb_dat_i & bmask;
  // rdata doubles as the current value of the addressed register for byte merging
  assign merged = (rdata & ~bmask) | wbits;
  assign clr    = (wr && word == 3'd5) ? wbits[GPIO_WIDTH-1:0] : '0;
  assign unused_bits = ^{merged, wbits, bus.wb_adr_i[1:0]};

  assign bus.wb_dat_o = dat;
  assign bus.wb_ack_o = ack;
  assign bus.wb_err_o = 1'b0;
  assign gpio_o       = data_out;
  assign gpio_oe_o    = dir;
  assign irq_o        = irq;

  always_comb begin
    rdata = '0;
    case (word)
      3'd0:    rdata = 32'(stable);
      3'd1:    rdata = 32'(data_out);
      3'd2:    rdata = 32'(dir);
      3'd3:    rdata = 32'(irq_mask);
      3'd4:    rdata = 32'(irq_edge);
      3'd5:    rdata = 32'(irq_status);
      3'd6:    rdata = 32'(debounce);
      default: rdata = '0;
    endcase
  end

  // A channel accepts the raw level once its counter has run out; a DEBOUNCE reload blocks that cycle
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      if (!deb_load && raw[i] != stable[i] && cnt[i] == '0) stable_nxt[i] = raw[i];
    end
    ev = (stable_nxt & ~stable & ~irq_edge) | (~stable_nxt & stable & irq_edge);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack        <= 1'b0;
      dat        <= '0;
      irq        <= 1'b0;
      deb_load   <= 1'b0;
      data_out   <= OUT_RESET;
      dir        <= DIR_RESET;
      irq_mask   <= '0;
      irq_edge   <= '0;
      irq_status <= '0;
      debounce   <= DB_RST;
      sync1      <= '0;
      raw        <= '0;
      stable     <= '0;
      for (int i = 0; i < GPIO_WIDTH; i++) cnt[i] <= DB_RST;
    end else begin
      ack      <= req;
      deb_load <= wr && (word == 3'd6) && (|bus.wb_sel_i);
      if (req) dat <= rdata;
      if (wr) begin
        case (word)
          3'd1:    data_out <= merged[GPIO_WIDTH-1:0];
          3'd2:    dir      <= merged[GPIO_WIDTH-1:0];
          3'd3:    irq_mask <= merged[GPIO_WIDTH-1:0];
          3'd4:    irq_edge <= merged[GPIO_WIDTH-1:0];
          3'd6:    debounce <= merged[DEBOUNCE_WIDTH-1:0];
          default: ;
        endcase
      end
      // A new event outranks a simultaneous write-one-to-clear
      irq_status <= (irq_status & ~clr) | ev;
      irq        <= |(irq_status & irq_mask);
      sync1      <= gpio_i;
      raw        <= sync1;
      stable     <= stable_nxt;
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        if (deb_load || raw[i] == stable[i] || cnt[i] == '0) cnt[i] <= debounce;
        else cnt[i] <= cnt[i] - DEBOUNCE_WIDTH'(1);
      end
    end
  end
endmodule
